// File: rtl/qk_score_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qk_score_scheduler
// Purpose  : Sequences Q x K score computation for one attention tile through
//            a single shared dot_product unit. Walks (q_idx, k_idx) in
//            row-major order, issues paired Q/K handshakes under a credit
//            limit, and tags each returned score with its indices and a
//            row-last marker for the softmax stage.
// Ports    : clk, rst (async, active-low)
//            start_i, cfg_num_q_i, cfg_num_k_i    tile control / config
//            busy_o, done_o, err_o                 status
//            dp_q_vld_o/dp_k_vld_o, dp_q_rdy_i/dp_k_rdy_i, q_idx_o, k_idx_o
//                                                  issue path
//            dp_s_vld_i, dp_s_rdy_o, dp_s_i        score return from dot_product
//            s_vld_o, s_rdy_i, s_out_o, s_q_idx_o, s_k_idx_o, s_row_last_o
//                                                  tagged score downstream
// Config   : CAUSAL_MASK_EN - when defined, row q visits k = 0..min(q, num_k-1)
// Revision : 1.0 - initial release
// ============================================================================
module qk_score_scheduler #(
  parameter int MAX_Q   = 64,
  parameter int MAX_K   = 64,
  parameter int IDX_W   = 6,
  parameter int SCORE_W = 8,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [IDX_W:0]     cfg_num_q_i,
  input  logic [IDX_W:0]     cfg_num_k_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               dp_q_vld_o,
  output logic               dp_k_vld_o,
  input  logic               dp_q_rdy_i,
  input  logic               dp_k_rdy_i,
  output logic [IDX_W-1:0]   q_idx_o,
  output logic [IDX_W-1:0]   k_idx_o,
  input  logic               dp_s_vld_i,
  output logic               dp_s_rdy_o,
  input  logic [SCORE_W-1:0] dp_s_i,
  output logic               s_vld_o,
  input  logic               s_rdy_i,
  output logic [SCORE_W-1:0] s_out_o,
  output logic [IDX_W-1:0]   s_q_idx_o,
  output logic [IDX_W-1:0]   s_k_idx_o,
  output logic               s_row_last_o
);

  localparam int TAG_W = 2 * IDX_W + 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [IDX_W:0]   c_max_q    = (IDX_W + 1)'(MAX_Q);
  localparam logic [IDX_W:0]   c_max_k    = (IDX_W + 1)'(MAX_K);
  localparam logic [CNT_W-1:0] c_max_out  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(MAX_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W:0]     num_q_q, num_k_q;
  logic [IDX_W-1:0]   q_idx_q, k_idx_q;
  logic               busy_q, done_q, err_q, vld_q;

  // Tag FIFO: one entry per issued-but-unreturned pair; its occupancy is the
  // outstanding-credit count.
  logic [TAG_W-1:0]   tag_mem_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_issue, w_pop, w_empty, w_drop, err_d;
  logic               w_row_last, w_q_last;
  logic [IDX_W-1:0]   w_k_max, w_k_end;
  logic [IDX_W:0]     w_cfg_q, w_cfg_k;
  logic [TAG_W-1:0]   w_head;

  always_comb begin
    w_issue = vld_q & dp_q_rdy_i & dp_k_rdy_i;
    w_empty = (cnt_q == '0);
    w_pop   = dp_s_vld_i & s_rdy_i & ~w_empty;
    // A score with no tag to match is accepted and discarded.
    w_drop  = dp_s_vld_i & w_empty;
    cnt_d   = cnt_q + CNT_W'(w_issue) - CNT_W'(w_pop);

    // Oversized configurations are clamped to the tile limits.
    w_cfg_q = (cfg_num_q_i > c_max_q) ? c_max_q : cfg_num_q_i;
    w_cfg_k = (cfg_num_k_i > c_max_k) ? c_max_k : cfg_num_k_i;

    w_k_max = IDX_W'(num_k_q - 1'b1);
`ifdef CAUSAL_MASK_EN
    w_k_end = (q_idx_q < w_k_max) ? q_idx_q : w_k_max;
`else
    w_k_end = w_k_max;
`endif
    w_row_last = (k_idx_q == w_k_end);
    w_q_last   = (q_idx_q == IDX_W'(num_q_q - 1'b1));

    // A new start clears the sticky error, unless a stray score lands in
    // that very cycle.
    if (state_q == ST_IDLE && start_i) err_d = w_drop;
    else                               err_d = err_q | w_drop;

    w_head = tag_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MAX_OUT; i++) tag_mem_q[i] <= '0;
    end else begin
      if (w_issue) begin
        tag_mem_q[wr_ptr_q] <= {q_idx_q, k_idx_q, w_row_last};
        wr_ptr_q            <= (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      num_q_q <= '0;
      num_k_q <= '0;
      q_idx_q <= '0;
      k_idx_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            num_q_q <= w_cfg_q;
            num_k_q <= w_cfg_k;
            q_idx_q <= '0;
            k_idx_q <= '0;
            busy_q  <= 1'b1;
            if (w_cfg_q == '0 || w_cfg_k == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
              vld_q   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // Valid follows the post-update credit count, so a pop at the
          // credit limit re-opens issue one cycle later.
          vld_q <= (cnt_d < c_max_out);
          if (w_issue) begin
            if (w_row_last) begin
              k_idx_q <= '0;
              if (w_q_last) begin
                state_q <= ST_DRAIN;
                vld_q   <= 1'b0;
              end else begin
                q_idx_q <= q_idx_q + 1'b1;
              end
            end else begin
              k_idx_q <= k_idx_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign dp_q_vld_o = vld_q;
  assign dp_k_vld_o = vld_q;
  assign q_idx_o    = q_idx_q;
  assign k_idx_o    = k_idx_q;

  // Return path: zero-latency pass-through with tags from the FIFO head.
  assign s_vld_o      = dp_s_vld_i & ~w_empty;
  assign dp_s_rdy_o   = w_empty ? dp_s_vld_i : s_rdy_i;
  assign s_out_o      = dp_s_i;
  assign s_q_idx_o    = w_empty ? '0 : w_head[TAG_W-1 -: IDX_W];
  assign s_k_idx_o    = w_empty ? '0 : w_head[IDX_W:1];
  assign s_row_last_o = w_empty ? 1'b0 : w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_qk_score_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_qk_score_scheduler
// Purpose  : Directed self-checking bench for qk_score_scheduler with a
//            one-cycle-latency in-order dot_product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qk_score_scheduler;

  localparam int IDX_W   = 6;
  localparam int SCORE_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, dp_q_rdy, dp_k_rdy, s_rdy;
  logic [IDX_W:0]     cfg_num_q, cfg_num_k;
  logic               busy, done, err, dp_q_vld, dp_k_vld, dp_s_rdy, s_vld, s_row_last;
  logic [IDX_W-1:0]   q_idx, k_idx, s_q_idx, s_k_idx;
  logic [SCORE_W-1:0] s_out;
  wire                dp_s_vld;
  wire  [SCORE_W-1:0] dp_s;

  // dot_product model: returns q*16+k one cycle after issue, in order.
  logic               ret_en, inj_vld, mvld;
  logic [SCORE_W-1:0] mhead;
  logic [SCORE_W-1:0] mq[$];
  assign dp_s_vld = rst & (ret_en ? mvld : inj_vld);
  assign dp_s     = ret_en ? mhead : '0;

  qk_score_scheduler dut (
    .clk(clk), .rst(rst), .start_i(start),
    .cfg_num_q_i(cfg_num_q), .cfg_num_k_i(cfg_num_k),
    .busy_o(busy), .done_o(done), .err_o(err),
    .dp_q_vld_o(dp_q_vld), .dp_k_vld_o(dp_k_vld),
    .dp_q_rdy_i(dp_q_rdy), .dp_k_rdy_i(dp_k_rdy),
    .q_idx_o(q_idx), .k_idx_o(k_idx),
    .dp_s_vld_i(dp_s_vld), .dp_s_rdy_o(dp_s_rdy), .dp_s_i(dp_s),
    .s_vld_o(s_vld), .s_rdy_i(s_rdy), .s_out_o(s_out),
    .s_q_idx_o(s_q_idx), .s_k_idx_o(s_k_idx), .s_row_last_o(s_row_last)
  );

  int total = 0;
  int bad   = 0;
  int iss_q[$], iss_k[$], pop_q[$], pop_k[$], pop_l[$], pop_s[$];
  int done_cnt, pops_at_done;
  bit vld_seen, vld_split;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      mvld  <= 1'b0;
      mhead <= '0;
    end else begin
      if (ret_en && dp_s_vld && dp_s_rdy && mq.size() > 0) void'(mq.pop_front());
      if (s_vld && s_rdy) begin
        pop_q.push_back(int'(s_q_idx));
        pop_k.push_back(int'(s_k_idx));
        pop_l.push_back(int'(s_row_last));
        pop_s.push_back(int'(s_out));
      end
      if (dp_q_vld && dp_q_rdy && dp_k_rdy) begin
        iss_q.push_back(int'(q_idx));
        iss_k.push_back(int'(k_idx));
        mq.push_back(SCORE_W'(int'(q_idx) * 16 + int'(k_idx)));
      end
      if (done) begin
        done_cnt++;
        pops_at_done = pop_q.size();
      end
      mvld  <= (mq.size() != 0);
      mhead <= (mq.size() != 0) ? mq[0] : '0;
    end
    if (dp_q_vld) vld_seen = 1'b1;
    if (dp_q_vld !== dp_k_vld) vld_split = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete(); iss_k.delete();
    pop_q.delete(); pop_k.delete(); pop_l.delete(); pop_s.delete();
    done_cnt = 0; pops_at_done = 0; vld_seen = 1'b0;
  endtask

  task automatic start_tile(input int nq, input int nk);
    cfg_num_q = (IDX_W + 1)'(nq);
    cfg_num_k = (IDX_W + 1)'(nk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt != d0), 32'd1);
  endtask

  // Checks the issue and return logs against a row-major walk of the tile.
  task automatic check_walk(input string tag, input int nq, input int nk, input bit mask);
    int i;
    int kend;
    i = 0;
    for (int q = 0; q < nq; q++) begin
      kend = nk - 1;
      if (mask && q < kend) kend = q;
      for (int k = 0; k <= kend; k++) begin
        if (i < iss_q.size()) chk({tag, "_iss"}, 32'(iss_q[i] * 64 + iss_k[i]), 32'(q * 64 + k));
        if (i < pop_q.size()) begin
          chk({tag, "_tag"}, 32'(pop_q[i] * 64 + pop_k[i]), 32'(q * 64 + k));
          chk({tag, "_last"}, 32'(pop_l[i]), 32'(k == kend));
          chk({tag, "_score"}, 32'(pop_s[i]), 32'((q * 16 + k) % 256));
        end
        i++;
      end
    end
    chk({tag, "_niss"}, 32'(iss_q.size()), 32'(i));
    chk({tag, "_npop"}, 32'(pop_q.size()), 32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_num_q = '0; cfg_num_k = '0;
    dp_q_rdy = 1'b1; dp_k_rdy = 1'b1; s_rdy = 1'b1;
    ret_en = 1'b1; inj_vld = 1'b0;
    vld_split = 1'b0;
    clear_logs();
    tick(); tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vld", 32'({dp_q_vld, dp_k_vld}), 32'd0);
    chk("rst_idx", 32'({q_idx, k_idx}), 32'd0);
    chk("rst_svld", 32'({s_vld, dp_s_rdy}), 32'd0);
    rst = 1'b1;
    tick();

    // 2x3 tile, always ready; a start held while busy is ignored
    clear_logs();
    start_tile(2, 3);
    chk("t1_busy", 32'(busy), 32'd1);
    cfg_num_q = 7'd1;
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done("t1_done_seen", 50);
    chk("t1_busy_after", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_walk("t1", 2, 3, 1'b0);

    // Downstream stall: credit limit of 4, then drain
    clear_logs();
    s_rdy = 1'b0;
    start_tile(1, 8);
    repeat (12) tick();
    chk("t2_niss_stall", 32'(iss_q.size()), 32'd4);
    chk("t2_vld_stall", 32'(dp_q_vld), 32'd0);
    chk("t2_busy_stall", 32'(busy), 32'd1);
    s_rdy = 1'b1;
    wait_done("t2_done_seen", 100);
    chk("t2_pops_at_done", 32'(pops_at_done), 32'd8);
    check_walk("t2", 1, 8, 1'b0);

    // One ready alone never issues
    clear_logs();
    dp_k_rdy = 1'b0;
    start_tile(1, 1);
    repeat (5) tick();
    chk("t3_niss_hold", 32'(iss_q.size()), 32'd0);
    chk("t3_vld_hold", 32'(dp_q_vld), 32'd1);
    chk("t3_idx_hold", 32'({q_idx, k_idx}), 32'd0);
    dp_k_rdy = 1'b1;
    tick();
    chk("t3_niss_first", 32'(iss_q.size()), 32'd1);
    wait_done("t3_done_seen", 50);
    check_walk("t3", 1, 1, 1'b0);

    // Empty tile: done two cycles after start, nothing issued
    clear_logs();
    cfg_num_q = 7'd2;
    cfg_num_k = 7'd0;
    start = 1'b1;
    tick();
    chk("t4_busy_c1", 32'(busy), 32'd1);
    chk("t4_done_c1", 32'(done), 32'd0);
    tick();
    start = 1'b0;
    chk("t4_done_c2", 32'(done), 32'd1);
    chk("t4_busy_c2", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("t4_done_c3", 32'(done), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_no_vld", 32'(vld_seen), 32'd0);

    // Stray score with empty tag FIFO: dropped, sticky err, cleared by start
    ret_en = 1'b0;
    inj_vld = 1'b1;
    #1;
    chk("t5_drop_rdy", 32'(dp_s_rdy), 32'd1);
    chk("t5_drop_svld", 32'(s_vld), 32'd0);
    tick();
    inj_vld = 1'b0;
    chk("t5_err_set", 32'(err), 32'd1);
    tick(); tick();
    chk("t5_err_sticky", 32'(err), 32'd1);
    ret_en = 1'b1;
    clear_logs();
    start_tile(1, 1);
    chk("t5_err_clear", 32'(err), 32'd0);
    wait_done("t5_done_seen", 50);

    // 3x3 tile, masked or full depending on build
    clear_logs();
    start_tile(3, 3);
    wait_done("t6_done_seen", 100);
`ifdef CAUSAL_MASK_EN
    check_walk("t6", 3, 3, 1'b1);
`else
    check_walk("t6", 3, 3, 1'b0);
`endif

    // Reset mid-tile after 3 issues, then replay from (0,0)
    clear_logs();
    start_tile(1, 8);
    for (int n = 0; n < 20 && iss_q.size() < 3; n++) tick();
    chk("t7_niss_pre", 32'(iss_q.size()), 32'd3);
    rst = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_vld", 32'({dp_q_vld, dp_k_vld}), 32'd0);
    chk("t7_idx", 32'({q_idx, k_idx}), 32'd0);
    chk("t7_ret", 32'({s_vld, dp_s_rdy, done, err}), 32'd0);
    chk("t7_tag", 32'({s_q_idx, s_k_idx, s_row_last}), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_logs();
    start_tile(1, 2);
    wait_done("t7_done_seen", 50);
    check_walk("t7", 1, 2, 1'b0);

    chk("vld_pair_equal", 32'(vld_split), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
